// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline control: tracks EX..WB records, detects RAW hazards against ID, drives issue/forwarding.
// Optional operand forwarding is enabled by defining the FWD_EN macro; without it every RAW match stalls.
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 3,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]     id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          id_dst_we,
  input  logic [REG_AW-1:0]             id_dst_addr,
  input  logic                          id_is_load,
  input  logic                          flush,
  input  logic                          pipe_hold,
  output logic                          id_allowin,
  output logic [NSTAGE-1:0]             stage_valid,
  output logic [NUM_SRC*$clog2(NSTAGE+1)-1:0] fwd_sel,
  output logic [CNT_W-1:0]              stall_cnt
);
  localparam int SELW = $clog2(NSTAGE+1);

  // Handshake: id_valid is the ID-side valid, id_allowin is its ready and already
  // includes id_valid; the instruction moves into EX on a clk edge where id_allowin=1.

  logic [NSTAGE-1:0] e_valid;
  logic [NSTAGE-1:0] e_we;
  logic [NSTAGE-1:0] e_load;
  logic [REG_AW-1:0] e_dst [NSTAGE];

  logic              hazard;
  logic              stall_event;
  logic [REG_AW-1:0] src;
  logic              hit;
`ifdef FWD_EN
  logic              hit_ok;
  logic [SELW-1:0]   hit_sel;
`else
  logic              unused_load;
  assign unused_load = ^{e_load, LOAD_STAGE[0]};
`endif

  // Scan oldest to youngest so the youngest matching entry is the one left in hit_*.
  always_comb begin
    hazard  = 1'b0;
    fwd_sel = '0;
    src     = '0;
    hit     = 1'b0;
`ifdef FWD_EN
    hit_ok  = 1'b0;
    hit_sel = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      src = id_src_addr[i*REG_AW +: REG_AW];
      hit = 1'b0;
`ifdef FWD_EN
      hit_ok  = 1'b0;
      hit_sel = '0;
`endif
      for (int k = NSTAGE-1; k >= 0; k--) begin
        if (id_src_used[i] && (src != '0) && e_valid[k] && e_we[k] && (e_dst[k] == src)) begin
          hit = 1'b1;
`ifdef FWD_EN
          hit_ok  = !(e_load[k] && (k < LOAD_STAGE));
          hit_sel = SELW'(k + 1);
`endif
        end
      end
`ifdef FWD_EN
      if (hit && !hit_ok) hazard = 1'b1;
      if (hit && hit_ok) fwd_sel[i*SELW +: SELW] = hit_sel;
`else
      if (hit) hazard = 1'b1;
`endif
    end
  end

  assign id_allowin  = id_valid & ~flush & ~pipe_hold & ~hazard;
  assign stall_event = id_valid & ~flush & ~pipe_hold & hazard;
  assign stage_valid = e_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_valid   <= '0;
      e_we      <= '0;
      e_load    <= '0;
      for (int k = 0; k < NSTAGE; k++) e_dst[k] <= '0;
      stall_cnt <= '0;
    end else begin
      if (!pipe_hold) begin
        for (int k = NSTAGE-1; k > 0; k--) begin
          e_valid[k] <= e_valid[k-1];
          e_we[k]    <= e_we[k-1];
          e_load[k]  <= e_load[k-1];
          e_dst[k]   <= e_dst[k-1];
        end
        // Payload fields of a bubble are don't-care; only valid matters.
        e_valid[0] <= id_allowin;
        e_we[0]    <= id_dst_we;
        e_load[0]  <= id_is_load;
        e_dst[0]   <= id_dst_addr;
      end
      if (stall_event && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl (NSTAGE=3, LOAD_STAGE=1, CNT_W=2 to reach saturation).
// Each row is driven at the falling edge; outputs are compared just before the next rising edge.
module tb_pipe_hazard_ctrl;
  localparam int NSTAGE = 3;
  localparam int REG_AW = 5;
  localparam int NUM_SRC = 2;
  localparam int CNT_W = 2;
  localparam int SELW = 2;
  localparam int W = 1 + NSTAGE + 2*SELW + CNT_W;

  logic                      clk;
  logic                      resetn;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      id_dst_we;
  logic [REG_AW-1:0]         id_dst_addr;
  logic                      id_is_load;
  logic                      flush;
  logic                      pipe_hold;
  logic                      id_allowin;
  logic [NSTAGE-1:0]         stage_valid;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;

  pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
                     .LOAD_STAGE(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_we(id_dst_we), .id_dst_addr(id_dst_addr),
    .id_is_load(id_is_load), .flush(flush), .pipe_hold(pipe_hold),
    .id_allowin(id_allowin), .stage_valid(stage_valid), .fwd_sel(fwd_sel),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              v;
    logic [REG_AW-1:0] s0;
    logic [REG_AW-1:0] s1;
    logic [1:0]        used;
    logic              we;
    logic [REG_AW-1:0] dst;
    logic              ld;
    logic              fl;
    logic              hd;
    logic              ea;
    logic [NSTAGE-1:0] esv;
    logic [SELW-1:0]   ef0;
    logic [SELW-1:0]   ef1;
    logic [CNT_W-1:0]  ecnt;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  function automatic vec_t mk(int rst, int v, int s0, int s1, int used, int we, int dst,
                              int ld, int fl, int hd, int ea, int esv, int ef0, int ef1,
                              int ecnt);
    vec_t r;
    r.rst = rst[0]; r.v = v[0]; r.s0 = s0[REG_AW-1:0]; r.s1 = s1[REG_AW-1:0];
    r.used = used[1:0]; r.we = we[0]; r.dst = dst[REG_AW-1:0]; r.ld = ld[0];
    r.fl = fl[0]; r.hd = hd[0]; r.ea = ea[0]; r.esv = esv[NSTAGE-1:0];
    r.ef0 = ef0[SELW-1:0]; r.ef1 = ef1[SELW-1:0]; r.ecnt = ecnt[CNT_W-1:0];
    return r;
  endfunction

  // driver
  task automatic drive(input vec_t r);
    resetn      = r.rst;
    id_valid    = r.v;
    id_src_addr = {r.s1, r.s0};
    id_src_used = r.used;
    id_dst_we   = r.we;
    id_dst_addr = r.dst;
    id_is_load  = r.ld;
    flush       = r.fl;
    pipe_hold   = r.hd;
    exp_q.push_back({r.ea, r.esv, r.ef0, r.ef1, r.ecnt});
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  // scoreboard
  task automatic compare(input int row);
    logic [W-1:0] e;
    logic [SELW-1:0] f0;
    logic [SELW-1:0] f1;
    e  = exp_q.pop_front();
    f0 = fwd_sel[SELW-1:0];
    f1 = fwd_sel[2*SELW-1:SELW];
    chk("id_allowin",  row, int'(id_allowin),  int'(e[W-1]));
    chk("stage_valid", row, int'(stage_valid), int'(e[W-2 -: NSTAGE]));
    chk("fwd_sel0",    row, int'(f0),          int'(e[2*SELW+CNT_W-1 -: SELW]));
    chk("fwd_sel1",    row, int'(f1),          int'(e[SELW+CNT_W-1 -: SELW]));
    chk("stall_cnt",   row, int'(stall_cnt),   int'(e[CNT_W-1:0]));
  endtask

  initial begin
    //             rst v s0 s1 used we dst ld fl hd | ea sv     f0 f1 cnt
`ifdef FWD_EN
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 2'b11, 1, 3, 0, 0, 0,  1, 3'b000, 0, 0, 0)); // add r3
    vecs.push_back(mk(1, 1, 3, 0, 2'b01, 1, 5, 0, 0, 0,  1, 3'b001, 1, 0, 0)); // forward from EX
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0,  1, 3'b011, 0, 0, 0)); // write r0
    vecs.push_back(mk(1, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0,  1, 3'b111, 0, 0, 0)); // read r0
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 4, 1, 0, 0,  1, 3'b111, 0, 0, 0)); // ld r4
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 12, 0, 1, 0, 0, 3'b111, 0, 0, 0)); // flush in stall
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 12, 0, 0, 0, 1, 3'b110, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 6, 1, 0, 0,  1, 3'b101, 0, 0, 0)); // ld r6
    vecs.push_back(mk(1, 1, 12, 6, 2'b11, 1, 13, 0, 0, 0, 0, 3'b011, 2, 0, 0));
    vecs.push_back(mk(1, 1, 12, 6, 2'b11, 1, 13, 0, 0, 0, 1, 3'b110, 3, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 7, 0, 0, 0,  1, 3'b101, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 8, 1, 0, 0,  1, 3'b011, 0, 0, 1)); // ld r8
    vecs.push_back(mk(1, 1, 8, 0, 2'b01, 0, 0, 0, 0, 1,  0, 3'b111, 0, 0, 1)); // hold
    vecs.push_back(mk(1, 1, 8, 0, 2'b01, 0, 0, 0, 0, 1,  0, 3'b111, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b111, 0, 0, 1)); // reset edge
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 4, 1, 0, 0,  1, 3'b000, 0, 0, 0)); // ld r4
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 11, 0, 0, 0, 0, 3'b001, 0, 0, 0)); // load-use stall
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 11, 0, 0, 0, 1, 3'b010, 2, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b101, 0, 0, 1));
`else
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 2'b11, 1, 3, 0, 0, 0,  1, 3'b000, 0, 0, 0)); // add r3
    vecs.push_back(mk(1, 1, 3, 0, 2'b01, 1, 5, 0, 0, 0,  0, 3'b001, 0, 0, 0)); // RAW stall x3
    vecs.push_back(mk(1, 1, 3, 0, 2'b01, 1, 5, 0, 0, 0,  0, 3'b010, 0, 0, 1));
    vecs.push_back(mk(1, 1, 3, 0, 2'b01, 1, 5, 0, 0, 0,  0, 3'b100, 0, 0, 2));
    vecs.push_back(mk(1, 1, 3, 0, 2'b01, 1, 5, 0, 0, 0,  1, 3'b000, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0,  1, 3'b001, 0, 0, 3)); // write r0
    vecs.push_back(mk(1, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0,  1, 3'b011, 0, 0, 3)); // read r0
    vecs.push_back(mk(1, 1, 0, 5, 2'b10, 1, 6, 0, 1, 0,  0, 3'b111, 0, 0, 3)); // flush on hazard
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b110, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 7, 0, 0, 0,  1, 3'b100, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 8, 0, 0, 0,  1, 3'b001, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 9, 0, 0, 0,  1, 3'b011, 0, 0, 3));
    vecs.push_back(mk(1, 1, 9, 0, 2'b01, 1, 10, 0, 0, 1, 0, 3'b111, 0, 0, 3)); // hold
    vecs.push_back(mk(1, 1, 9, 0, 2'b01, 1, 10, 0, 0, 1, 0, 3'b111, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b111, 0, 0, 3)); // reset edge
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 1, 4, 1, 0, 0,  1, 3'b000, 0, 0, 0)); // ld r4
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 11, 0, 1, 0, 0, 3'b001, 0, 0, 0)); // flush in stall
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 11, 0, 0, 0, 0, 3'b010, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 11, 0, 0, 0, 0, 3'b100, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4, 0, 2'b01, 1, 11, 0, 0, 0, 1, 3'b000, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 11, 2'b10, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 2)); // toward saturation
    vecs.push_back(mk(1, 1, 0, 11, 2'b10, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 11, 2'b10, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 11, 2'b10, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3));
`endif

    resetn = 1'b0; id_valid = 1'b0; id_src_addr = '0; id_src_used = '0;
    id_dst_we = 1'b0; id_dst_addr = '0; id_is_load = 1'b0; flush = 1'b0; pipe_hold = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      drive(vecs[r]);
      #2;
      compare(r);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
